pulse_stretcher: RTL and testbench

Converts single-cycle event strobes into clean level pulses of fixed high width followed by a guaranteed low gap, so each strobe produces exactly one distinct rising edge. It performs the inverse of our rising-edge detectors: pulse to level rather than level to pulse. It sits on the transmit side of slow or level-sensitive consumers, such as LEDs, off-chip lines and edge detectors in slower logic. Strobes arriving while a pulse is in progress are queued in a saturating pending counter and replayed in order.

---
 rtl/pulse_pkg.sv | 28 ++
 rtl/sat_counter.sv | 47 ++++
 rtl/pulse_stretcher.sv | 122 ++++++++++++
 tb/tb_pulse_stretcher.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module : pulse_pkg
// Brief  : Shared types and elaboration helpers for the pulse stretcher.
// Rev    : 1.0 - initial release
// ============================================================================
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Down-counter must hold the larger of the two window lengths minus one.
  function automatic int cnt_width(input int high_cycles, input int low_cycles);
    int m;
    m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_ok(input int high_cycles, input int low_cycles,
                                   input int pend_w);
    return (high_cycles >= 1) && (low_cycles >= 1) && (pend_w >= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up/down counter; inc at full is dropped and flagged.
// Rev    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         async_nreset,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o,
  output logic         full_o,
  output logic         drop_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign zero_o  = (count_q == '0);
  assign full_o  = (count_q == '1);
  assign count_o = count_q;
  // Simultaneous inc and dec cancel, so only a lone inc can overflow.
  assign drop_o  = inc_i && !dec_i && full_o;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !inc_i && !zero_o) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module : pulse_stretcher
// Brief  : Turns strobes into fixed-width high pulses with a guaranteed low gap.
// Rev    : 1.0 - initial release
// ============================================================================
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic pulse_in,
  output logic out,
  output logic busy,
  output logic overflow
);

  localparam int CNT_W = cnt_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CNT_W-1:0] C_HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);

  generate
    if (!params_ok(HIGH_CYCLES, LOW_CYCLES, PEND_W)) begin : g_param_check
      $error("pulse_stretcher: HIGH_CYCLES, LOW_CYCLES and PEND_W must all be >= 1");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q;

  logic              w_low_exit;
  logic              w_pend_inc;
  logic              w_pend_dec;
  logic              w_pend_zero;
  logic              w_pend_full;
  logic              w_pend_drop;
  logic [PEND_W-1:0] w_pend_count;
  logic              w_unused;

  assign w_low_exit = (state_q == ST_LOW) && (cnt_q == '0);

  // A strobe on the LOW exit cycle with nothing queued starts the next window
  // directly and never touches the pending counter.
  assign w_pend_inc = pulse_in && (state_q != ST_IDLE) && !(w_low_exit && w_pend_zero);
  assign w_pend_dec = w_low_exit && !w_pend_zero;

  sat_counter #(
    .W (PEND_W)
  ) u_pend (
    .clk          (clk),
    .async_nreset (async_nreset),
    .inc_i        (w_pend_inc),
    .dec_i        (w_pend_dec),
    .count_o      (w_pend_count),
    .zero_o       (w_pend_zero),
    .full_o       (w_pend_full),
    .drop_o       (w_pend_drop)
  );

  assign w_unused = ^{w_pend_count, w_pend_full};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pulse_in) begin
          state_d = ST_HIGH;
          cnt_d   = C_HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = C_LOW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (pulse_in || !w_pend_zero) begin
            state_d = ST_HIGH;
            cnt_d   = C_HIGH_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= w_pend_drop;
    end
  end

  assign out      = (state_q == ST_HIGH);
  assign busy     = (state_q != ST_IDLE);
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module : tb_pulse_stretcher
// Brief  : Randomized bench for pulse_stretcher against a window-schedule model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

  localparam int H    = 4;
  localparam int L    = 2;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic async_nreset = 1'b0;
  logic pulse_in = 1'b0;
  logic out;
  logic busy;
  logic overflow;

  pulse_stretcher #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PEND_W      (PW)
  ) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .pulse_in     (pulse_in),
    .out          (out),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int acc   = 0;
  int ovf_seen = 0;
  int rises = 0;
  logic prev_out = 1'b0;

  // Model: each accepted event owns a high window starting at a known cycle
  // (cycle k = state just after posedge k). Windows are spaced >= H+L apart.
  int starts[$];

  always @(posedge clk) begin
    prev_out <= out;
    if (out && !prev_out) rises <= rises + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int pend_at(input int e);
    int n = 0;
    foreach (starts[i]) if (starts[i] >= e) n++;
    return n;
  endfunction

  function automatic bit has_start(input int s);
    foreach (starts[i]) if (starts[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit would_drop(input int e);
    return (pend_at(e) == PMAX) && !has_start(e);
  endfunction

  task automatic step(input bit p);
    int  e;
    int  nxt;
    bit  dropped;
    bit  eo;
    bit  eb;
    pulse_in = p;
    @(posedge clk);
    cyc++;
    e = cyc;
    dropped = 1'b0;
    if (p) begin
      if (would_drop(e)) begin
        dropped = 1'b1;
      end else begin
        nxt = e;
        if (starts.size() > 0 && starts[$] + H + L > nxt) nxt = starts[$] + H + L;
        starts.push_back(nxt);
        acc++;
      end
    end
    while (starts.size() > 1 && starts[0] < e - 40) void'(starts.pop_front());
    @(negedge clk);
    eo = 1'b0;
    eb = 1'b0;
    foreach (starts[i]) begin
      if (starts[i] <= e && e < starts[i] + H)     eo = 1'b1;
      if (starts[i] <= e && e < starts[i] + H + L) eb = 1'b1;
    end
    if (overflow === 1'b1) ovf_seen++;
    chk("out", {31'd0, out}, {31'd0, eo});
    chk("busy", {31'd0, busy}, {31'd0, eb});
    chk("overflow", {31'd0, overflow}, {31'd0, dropped});
  endtask

  initial begin
    int r0;
    int a0;
    int o0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {31'd0, out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    async_nreset = 1'b1;

    // Single strobe from idle
    repeat (9) step(1'b0);
    step(1'b1);
    repeat (10) step(1'b0);

    // Three consecutive strobes
    o0 = ovf_seen;
    repeat (3) step(1'b1);
    repeat (24) step(1'b0);
    chk("three_no_ovf", ovf_seen - o0, 0);

    // Five consecutive strobes: one dropped with a 2-bit pending counter
    o0 = ovf_seen;
    r0 = rises;
    repeat (5) step(1'b1);
    repeat (32) step(1'b0);
    chk("five_ovf_pulses", ovf_seen - o0, 1);
    chk("five_windows", rises - r0, 4);

    // Strobe on the final LOW cycle with nothing pending
    step(1'b1);
    repeat (H + L - 1) step(1'b0);
    step(1'b1);
    chk("lowexit_out", {31'd0, out}, 32'd1);
    repeat (12) step(1'b0);

    // Asynchronous reset mid-HIGH with two events pending
    repeat (3) step(1'b1);
    step(1'b0);
    chk("pre_rst_out", {31'd0, out}, 32'd1);
    #1 async_nreset = 1'b0;
    #1;
    chk("async_rst_out", {31'd0, out}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    starts.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_nreset = 1'b1;
    repeat (15) step(1'b0);

    // Loopback: ~30% strobes, held off whenever one would be dropped
    r0 = rises;
    a0 = acc;
    o0 = ovf_seen;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 30) && !would_drop(cyc + 1));
    end
    repeat (40) step(1'b0);
    chk("loopback_edges", rises - r0, acc - a0);
    chk("loopback_no_ovf", ovf_seen - o0, 0);

    // Heavy random traffic with drops allowed
    r0 = rises;
    a0 = acc;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(99) < 55);
    end
    repeat (40) step(1'b0);
    chk("heavy_edges", rises - r0, acc - a0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
